fetch_queue: RTL and testbench

Circular instruction buffer between the fetch stage and the decoder. It captures `{pc, instruction}` pairs returned from instruction memory and presents them in program order to the decoder's `pc`/`instruction` inputs through a valid/ready handshake. It decouples fetch latency from decode and rename stalls, and discards all contents on a pipeline flush.

---
 rtl/rv32i_types.sv | 11 +
 rtl/fetch_queue.sv | 88 ++++++++
 tb/tb_fetch_queue.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types; fetch_pkt_t pairs a fetched PC with its instruction word.
package rv32i_types;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode circular buffer: 1-cycle latency (0 when empty with FETCH_QUEUE_BYPASS_EN),
// enq_ready drops when full, flush empties it; no enqueue into a slot freed in the same cycle.
module fetch_queue
  import rv32i_types::*;
#(
  parameter int width = 32,
  parameter int depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   enq_valid,
  input  logic [width-1:0]       enq_pc,
  input  logic [width-1:0]       enq_instr,
  output logic                   enq_ready,
  output logic                   deq_valid,
  output logic [width-1:0]       deq_pc,
  output logic [width-1:0]       deq_instr,
  input  logic                   deq_ready,
  output logic [$clog2(depth):0] count
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

  fetch_pkt_t       r_mem [depth];
  logic [AW-1:0]    r_hd;
  logic [AW-1:0]    r_tl;
  logic [AW:0]      r_count;

  fetch_pkt_t       w_enq_pkt;
  fetch_pkt_t       w_deq_pkt;
  logic             w_empty;
  logic             w_bypass;
  logic             w_enq_fire;
  logic             w_deq_fire;

  assign w_enq_pkt = '{pc: enq_pc, instruction: enq_instr};
  assign w_empty   = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass  = w_empty && enq_valid && !flush;
`else
  assign w_bypass  = 1'b0;
`endif

  assign enq_ready = (r_count != FULL_CNT);
  assign deq_valid = !w_empty || w_bypass;
  assign w_deq_pkt = w_bypass ? w_enq_pkt : r_mem[r_hd];
  assign deq_pc    = w_deq_pkt.pc;
  assign deq_instr = w_deq_pkt.instruction;
  assign count     = r_count;

  // A bypassed pair consumed in the same cycle never touches storage.
  assign w_enq_fire = enq_valid && enq_ready && !flush && !(w_bypass && deq_ready);
  assign w_deq_fire = !w_empty && deq_ready && !flush;

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_mem[r_tl] <= w_enq_pkt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hd    <= '0;
      r_tl    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_hd    <= '0;
      r_tl    <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_fire) begin
        r_tl <= r_tl + 1'b1;
      end
      if (w_deq_fire) begin
        r_hd <= r_hd + 1'b1;
      end
      if (w_enq_fire && !w_deq_fire) begin
        r_count <= r_count + 1'b1;
      end else if (w_deq_fire && !w_enq_fire) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus random bench for fetch_queue against a queue-based model of the buffer.
module tb_fetch_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic [31:0] enq_pc;
  logic [31:0] enq_instr;
  logic        enq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic        deq_ready;
  logic [3:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] mq[$];
  logic        seen_200 = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(.width(32), .depth(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .deq_ready (deq_ready),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive, check pre-edge outputs, advance the model.
  task automatic step(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                      input logic dr, input logic fl);
    int   sz;
    logic byp;
    enq_valid = ev;
    enq_pc    = pc;
    enq_instr = ins;
    deq_ready = dr;
    flush     = fl;
    #1;
    sz  = mq.size();
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && ev && !fl;
`endif
    chk("count", 64'(count), 64'(sz));
    chk("enq_ready", 64'(enq_ready), 64'(sz != DEPTH));
    chk("deq_valid", 64'(deq_valid), 64'((sz != 0) || byp));
    if (byp) begin
      chk("byp_pc", 64'(deq_pc), 64'(pc));
      chk("byp_instr", 64'(deq_instr), 64'(ins));
    end else if (sz != 0) begin
      chk("deq_pc", 64'(deq_pc), 64'(mq[0][63:32]));
      chk("deq_instr", 64'(deq_instr), 64'(mq[0][31:0]));
    end
    if (deq_valid && dr && !fl && deq_pc == 32'h200) seen_200 = 1'b1;
    if (fl) begin
      mq.delete();
    end else if (!(byp && dr)) begin
      if (ev && sz != DEPTH) mq.push_back({pc, ins});
      if (dr && sz != 0) void'(mq.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_pc = '0; enq_instr = '0; deq_ready = 1'b0;
    #2;
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single entry then drain
    step(1'b1, 32'h60, 32'h0050_0093, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill to full, 9th dropped, drain in order
    for (int k = 0; k < DEPTH; k++) step(1'b1, 32'(4*k), 32'hA000_0000 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Steady stream across pointer wrap
    step(1'b1, 32'h100, 32'hB000_0000, 1'b0, 1'b0);
    for (int k = 1; k < 20; k++) step(1'b1, 32'h100 + 32'(4*k), 32'hB000_0000 + 32'(k), 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with count=5 and a concurrent enqueue/dequeue
    for (int k = 0; k < 5; k++) step(1'b1, 32'h180 + 32'(4*k), 32'hC000_0000 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'h200, 32'hC0DE, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flushed_pc_never_out", 64'(seen_200), 64'd0);

    // Async reset between edges with count=3
    for (int k = 0; k < 3; k++) step(1'b1, 32'h240 + 32'(4*k), 32'hD000_0000 + 32'(k), 1'b0, 1'b0);
    enq_valid = 1'b0; deq_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_deq_valid", 64'(deq_valid), 64'd0);
    chk("arst_enq_ready", 64'(enq_ready), 64'd1);
    chk("arst_count", 64'(count), 64'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Enqueue into empty queue with consumer ready (bypass case when enabled)
    step(1'b1, 32'h300, 32'hE000_0300, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
    for (int k = 0; k < DEPTH + 1; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
